sm83_irq_ctrl: RTL and testbench
================================

Name: sm83_irq_ctrl

Overview:
- Interrupt controller and dispatch sequencer for the SM83 core.
- Owns the IF and IE registers and the IME flag, including EI-delay, DI and RETI semantics.
- Arbitrates pending sources by fixed priority and steps the core's control unit through the 5-M-cycle interrupt dispatch.
- Generates the HALT wake signal; sits beside the control FSM and is advanced by the core's M-cycle strobe.

Parameters:
- NUM_IRQ, 5, number of sources; bit 0 has the highest priority.
- VEC_BASE, 8'h40, vector address of source 0.
- VEC_STRIDE, 8, vector spacing in bytes.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- m_tick  in  1  one-clk strobe marking the end of an M-cycle; all sequencing advances only on it
- instr_boundary  in  1  current M-cycle is the last of an instruction; qualified by m_tick
- ctl_ei / ctl_di / ctl_reti  in  1 each  decoded op completing at this boundary; qualified by m_tick & instr_boundary
- halted  in  1  core is in HALT
- irq_src  in  NUM_IRQ  one-clk set pulses from peripherals
- if_we  in  1  IF write strobe
- if_wdata  in  NUM_IRQ  IF write data
- ie_we  in  1  IE write strobe
- ie_wdata  in  8  IE write data
- if_rdata  out  8  {3'b111, IF}
- ie_rdata  out  8  full 8-bit IE
- ime  out  1  interrupt master enable
- dispatch  out  1  dispatch sequence active; core suppresses opcode fetch
- disp_stage  out  3  0 IDLE, 1 WAIT1, 2 WAIT2, 3 PUSH_HI, 4 PUSH_LO, 5 JUMP
- vector  out  8  low byte of the jump target; high byte is 0
- vector_valid  out  1  high in JUMP
- wake  out  1  combinational: |(IE[NUM_IRQ-1:0] & IF)
- halt_bug  out  1  see Optional Feature

Behaviour:
- Reset (rst_n=0 at a clk edge): IF=0, IE=0, ime=0, ime_pending=0, state IDLE, vector=0, all strobes 0. Reset mid-dispatch aborts the sequence with no residual state.
- IF update order within one clk: a write replaces IF; the dispatch clear is applied next; irq_src pulses are ORed last, so a set always wins over a clear of the same bit.
- EI: on its boundary, ime_pending<=1.
  - At the next boundary, ime<=1, ime_pending<=0, and the dispatch check at that boundary already treats IME as 1. Exactly one instruction executes after EI.
- DI: ime<=0 and ime_pending<=0 immediately. EI followed by DI never enables.
- RETI: ime<=1 immediately.
- Dispatch check: at m_tick & instr_boundary, if IME_eff & wake & ~halted, enter WAIT1 and set ime<=0.
- While halted: wake asserts regardless of ime. The core leaves HALT, and the next boundary performs the check.
- FSM: each state advances on m_tick. Sequence is WAIT1 -> WAIT2 -> PUSH_HI -> PUSH_LO -> JUMP -> IDLE. dispatch=1 from WAIT1 through JUMP.
- Arbitration: the lowest set bit k of IE&IF is sampled at the m_tick that ends PUSH_HI, not at entry. The PC-high push may write IE (0xFFFF) and cancel the interrupt.
  - k exists: vector<=VEC_BASE+k*VEC_STRIDE and IF[k] is cleared on that same m_tick.
  - None pending: vector<=8'h00 and no IF bit is cleared.
- JUMP: vector_valid=1 for the whole M-cycle. The core loads PC={8'h00,vector}.
- Register writes during dispatch take effect normally, subject to the PUSH_HI sampling rule.
- ie/if reads are combinational from the registers.

Optional Feature:
- Macro: SM83_HALT_BUG_EN.
- Defined:
  - halt_bug pulses for one m_tick when the core signals a HALT entry boundary (halted rises) while ime=0 and wake=1.
  - The core then skips the PC increment on the next fetch; the HALT itself does not stall.
- Undefined: halt_bug is tied to 0 and the HALT then falls through with the normal PC increment.

Test Plan:
- IE=0x1F, ime=1, irq_src=5'b00100 at boundary -> states 1..5 on successive m_ticks, vector=0x50, IF[2] cleared at PUSH_HI end, ime=0.
- IF=0x05, IE=0x05, ime=1 -> vector=0x40, IF=0x04 afterwards, second dispatch to 0x50 after RETI.
- EI at boundary N with IF=IE=0x01 -> no dispatch at N, dispatch at N+1. EI then DI -> no dispatch and ime stays 0.
- During PUSH_HI, ie_we with ie_wdata=0x00 -> vector=0x00, IF unchanged.
- Same clk as the IF[3] dispatch clear: irq_src[3] pulses -> IF[3]=1 afterwards. Also: if_we=0x00 with irq_src[1] in the same clk -> IF=0x02. Also: if_rdata reads 0xE2.
- halted=1, ime=0, IE=0x04, timer pulse -> wake=1, no dispatch. With SM83_HALT_BUG_EN, HALT entry with wake already 1 -> one halt_bug pulse.

Source files
------------

// File: rtl/sm83_irq_ctrl.sv
// sm83_irq_ctrl -- interrupt controller and dispatch sequencer for the SM83 core.
//
// Owns IF, IE and the IME flag (with EI delay, DI and RETI semantics),
// arbitrates pending sources by fixed priority (bit 0 highest), steps the
// control unit through the 5-M-cycle dispatch and produces the HALT wake.
// All sequencing advances only on the one-clk m_tick strobe.
//
// Optional feature: define SM83_HALT_BUG_EN to generate the halt_bug pulse;
// when undefined halt_bug is tied to 0.
//
// Ports:
//   clk, rst_n          core clock, synchronous active-low reset
//   m_tick              end-of-M-cycle strobe
//   instr_boundary      last M-cycle of an instruction (qualified by m_tick)
//   ctl_ei/di/reti      decoded op completing at this boundary
//   halted              core is in HALT
//   irq_src             one-clk set pulses from peripherals
//   if_we/if_wdata      IF write port
//   ie_we/ie_wdata      IE write port
//   if_rdata, ie_rdata  combinational register reads
//   ime                 interrupt master enable
//   dispatch            dispatch sequence active (WAIT1..JUMP)
//   disp_stage          0 IDLE,1 WAIT1,2 WAIT2,3 PUSH_HI,4 PUSH_LO,5 JUMP
//   vector/vector_valid jump target low byte, valid during JUMP
//   wake                |(IE & IF), independent of IME
//   halt_bug            HALT-bug PC-increment skip request
module sm83_irq_ctrl #(
  parameter int         NUM_IRQ    = 5,
  parameter logic [7:0] VEC_BASE   = 8'h40,
  parameter int         VEC_STRIDE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_tick,
  input  logic               instr_boundary,
  input  logic               ctl_ei,
  input  logic               ctl_di,
  input  logic               ctl_reti,
  input  logic               halted,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               if_we,
  input  logic [NUM_IRQ-1:0] if_wdata,
  input  logic               ie_we,
  input  logic [7:0]         ie_wdata,
  output logic [7:0]         if_rdata,
  output logic [7:0]         ie_rdata,
  output logic               ime,
  output logic               dispatch,
  output logic [2:0]         disp_stage,
  output logic [7:0]         vector,
  output logic               vector_valid,
  output logic               wake,
  output logic               halt_bug
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT1   = 3'd1,
    S_WAIT2   = 3'd2,
    S_PUSH_HI = 3'd3,
    S_PUSH_LO = 3'd4,
    S_JUMP    = 3'd5
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] if_q;
  logic [7:0]         ie_q;
  logic               ime_q;
  logic               ime_pending;
  logic [7:0]         vector_q;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pick_mask;
  logic [7:0]         pick_vec;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] if_next;
  logic               boundary, ei_b, di_b, reti_b;
  logic               ime_eff, take;

  assign pending  = ie_q[NUM_IRQ-1:0] & if_q;
  assign boundary = m_tick & instr_boundary;
  assign ei_b     = boundary & ctl_ei;
  assign di_b     = boundary & ctl_di;
  assign reti_b   = boundary & ctl_reti;

  // A pending EI promotes at this boundary, so the check already sees IME=1.
  // RETI enables at its own boundary; DI at its boundary wins over both.
  assign ime_eff = ~di_b & (ime_q | ime_pending | reti_b);
  assign take    = boundary & (state == S_IDLE) & ime_eff & wake & ~halted;

  // Lowest set bit wins: iterate high to low so the last hit is the lowest.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    pick_mask = '0;
    pick_vec  = 8'h00;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick_mask    = '0;
        pick_mask[i] = 1'b1;
        pick_vec     = VEC_BASE + 8'(i * VEC_STRIDE);
      end
    end
  end

  // IF update order: CPU write, then dispatch clear, then peripheral sets.
  assign clr_mask = (m_tick && state == S_PUSH_HI) ? pick_mask : '0;
  assign if_next  = ((if_we ? if_wdata : if_q) & ~clr_mask) | irq_src;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      if_q        <= '0;
      ie_q        <= 8'h00;
      ime_q       <= 1'b0;
      ime_pending <= 1'b0;
      vector_q    <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; later
      // assignments in this block intentionally override earlier ones.
      if_q <= if_next;
      if (ie_we) ie_q <= ie_wdata;

      if (di_b || take) begin
        ime_q       <= 1'b0;
        ime_pending <= 1'b0;
      end else begin
        if (boundary && ime_pending) begin
          ime_q       <= 1'b1;
          ime_pending <= 1'b0;
        end
        if (ei_b)   ime_pending <= 1'b1;
        if (reti_b) ime_q       <= 1'b1;
      end

      if (m_tick) begin
        unique case (state)
          S_IDLE:    if (take) state <= S_WAIT1;
          S_WAIT1:   state <= S_WAIT2;
          S_WAIT2:   state <= S_PUSH_HI;
          S_PUSH_HI: begin
            // Sampled here, not at entry: the PC-high push may rewrite IE.
            vector_q <= pick_vec;
            state    <= S_PUSH_LO;
          end
          S_PUSH_LO: state <= S_JUMP;
          S_JUMP:    state <= S_IDLE;
          default:   state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SM83_HALT_BUG_EN
  logic halted_d;
  logic halt_bug_q;

  // HALT entry (halted rising between ticks) with IME off and an interrupt
  // already pending: request one M-cycle of skipped PC increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_d   <= 1'b0;
      halt_bug_q <= 1'b0;
    end else if (m_tick) begin
      halted_d   <= halted;
      halt_bug_q <= halted & ~halted_d & ~ime_q & wake;
    end
  end

  assign halt_bug = halt_bug_q;
`else
  assign halt_bug = 1'b0;
`endif

  assign wake         = |pending;
  assign if_rdata     = {{(8 - NUM_IRQ){1'b1}}, if_q};
  assign ie_rdata     = ie_q;
  assign ime          = ime_q;
  assign dispatch     = (state != S_IDLE);
  assign disp_stage   = state;
  assign vector       = vector_q;
  assign vector_valid = (state == S_JUMP);

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// tb_sm83_irq_ctrl -- directed self-checking bench for sm83_irq_ctrl.
// Inputs change on the falling edge; outputs are compared on the falling
// edge after the rising edge that updates them. Each M-cycle is two clks
// with m_tick in the first.
module tb_sm83_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_tick;
  logic       instr_boundary;
  logic       ctl_ei, ctl_di, ctl_reti;
  logic       halted;
  logic [4:0] irq_src;
  logic       if_we;
  logic [4:0] if_wdata;
  logic       ie_we;
  logic [7:0] ie_wdata;
  logic [7:0] if_rdata, ie_rdata;
  logic       ime, dispatch, vector_valid, wake, halt_bug;
  logic [2:0] disp_stage;
  logic [7:0] vector;

  int checks = 0;
  int errors = 0;
  logic exp_hb;

  sm83_irq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .m_tick(m_tick), .instr_boundary(instr_boundary),
    .ctl_ei(ctl_ei), .ctl_di(ctl_di), .ctl_reti(ctl_reti), .halted(halted),
    .irq_src(irq_src), .if_we(if_we), .if_wdata(if_wdata), .ie_we(ie_we),
    .ie_wdata(ie_wdata), .if_rdata(if_rdata), .ie_rdata(ie_rdata), .ime(ime),
    .dispatch(dispatch), .disp_stage(disp_stage), .vector(vector),
    .vector_valid(vector_valid), .wake(wake), .halt_bug(halt_bug)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One M-cycle: tick clk carrying the boundary/op strobes and src pulses.
  task automatic mcyc(input logic bnd, input logic ei, input logic di,
                      input logic reti, input logic [4:0] src);
    @(negedge clk);
    m_tick = 1'b1; instr_boundary = bnd;
    ctl_ei = ei; ctl_di = di; ctl_reti = reti; irq_src = src;
    @(negedge clk);
    m_tick = 1'b0; instr_boundary = 1'b0;
    ctl_ei = 1'b0; ctl_di = 1'b0; ctl_reti = 1'b0; irq_src = '0;
  endtask

  task automatic write_if_src(input logic [4:0] d, input logic [4:0] src);
    @(negedge clk);
    if_we = 1'b1; if_wdata = d; irq_src = src;
    @(negedge clk);
    if_we = 1'b0; irq_src = '0;
  endtask

  task automatic write_ie(input logic [7:0] d);
    @(negedge clk);
    ie_we = 1'b1; ie_wdata = d;
    @(negedge clk);
    ie_we = 1'b0;
  endtask

  task automatic pulse_src(input logic [4:0] src);
    @(negedge clk);
    irq_src = src;
    @(negedge clk);
    irq_src = '0;
  endtask

  initial begin
`ifdef SM83_HALT_BUG_EN
    exp_hb = 1'b1;
`else
    exp_hb = 1'b0;
`endif
    rst_n = 1'b0; m_tick = 1'b0; instr_boundary = 1'b0;
    ctl_ei = 1'b0; ctl_di = 1'b0; ctl_reti = 1'b0; halted = 1'b0;
    irq_src = '0; if_we = 1'b0; if_wdata = '0; ie_we = 1'b0; ie_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst if_rdata", if_rdata, 8'hE0);
    check("rst ie_rdata", ie_rdata, 8'h00);
    check("rst ime", ime, 1'b0);
    check("rst dispatch", dispatch, 1'b0);
    check("rst stage", disp_stage, 3'd0);
    check("rst vector", vector, 8'h00);
    check("rst vvalid", vector_valid, 1'b0);
    check("rst wake", wake, 1'b0);
    check("rst halt_bug", halt_bug, 1'b0);

    // Basic dispatch of source 2
    write_ie(8'h1F);
    mcyc(1, 0, 0, 1, 5'b0);            // RETI with nothing pending: ime=1
    check("t1 ime on", ime, 1'b1);
    check("t1 stage idle", disp_stage, 3'd0);
    pulse_src(5'b00100);
    check("t1 if set", if_rdata, 8'hE4);
    check("t1 wake", wake, 1'b1);
    mcyc(1, 0, 0, 0, 5'b0);
    check("t1 stage1", disp_stage, 3'd1);
    check("t1 dispatch", dispatch, 1'b1);
    check("t1 ime cleared", ime, 1'b0);
    mcyc(0, 0, 0, 0, 5'b0);
    check("t1 stage2", disp_stage, 3'd2);
    mcyc(0, 0, 0, 0, 5'b0);
    check("t1 stage3", disp_stage, 3'd3);
    check("t1 if before arb", if_rdata, 8'hE4);
    mcyc(0, 0, 0, 0, 5'b0);
    check("t1 stage4", disp_stage, 3'd4);
    check("t1 vector", vector, 8'h50);
    check("t1 if cleared", if_rdata, 8'hE0);
    mcyc(0, 0, 0, 0, 5'b0);
    check("t1 stage5", disp_stage, 3'd5);
    check("t1 vvalid", vector_valid, 1'b1);
    mcyc(0, 0, 0, 0, 5'b0);
    check("t1 idle", disp_stage, 3'd0);
    check("t1 vvalid off", vector_valid, 1'b0);
    check("t1 dispatch off", dispatch, 1'b0);

    // Priority: IF=IE=0x05 -> source 0 first, source 2 after RETI
    write_ie(8'h05);
    mcyc(1, 0, 0, 1, 5'b0);
    check("t2 ime on", ime, 1'b1);
    write_if_src(5'h05, 5'b0);
    mcyc(1, 0, 0, 0, 5'b0);
    check("t2 stage1", disp_stage, 3'd1);
    repeat (3) mcyc(0, 0, 0, 0, 5'b0);
    check("t2 vector", vector, 8'h40);
    check("t2 if after", if_rdata, 8'hE4);
    repeat (2) mcyc(0, 0, 0, 0, 5'b0);
    check("t2 idle", disp_stage, 3'd0);
    check("t2 ime off", ime, 1'b0);
    mcyc(1, 0, 0, 1, 5'b0);            // RETI re-enables and dispatches source 2
    check("t2 reti stage1", disp_stage, 3'd1);
    repeat (3) mcyc(0, 0, 0, 0, 5'b0);
    check("t2 second vector", vector, 8'h50);
    check("t2 if empty", if_rdata, 8'hE0);
    repeat (2) mcyc(0, 0, 0, 0, 5'b0);
    check("t2 idle again", disp_stage, 3'd0);

    // EI delay
    write_ie(8'h01);
    write_if_src(5'h01, 5'b0);
    mcyc(1, 1, 0, 0, 5'b0);            // EI at boundary N
    check("t3 no disp at N", disp_stage, 3'd0);
    check("t3 ime still 0", ime, 1'b0);
    mcyc(1, 0, 0, 0, 5'b0);            // boundary N+1
    check("t3 disp at N+1", disp_stage, 3'd1);
    check("t3 ime cleared", ime, 1'b0);
    repeat (3) mcyc(0, 0, 0, 0, 5'b0);
    check("t3 vector", vector, 8'h40);
    repeat (2) mcyc(0, 0, 0, 0, 5'b0);
    check("t3 idle", disp_stage, 3'd0);

    // EI followed by DI never enables
    write_if_src(5'h01, 5'b0);
    mcyc(1, 1, 0, 0, 5'b0);
    mcyc(1, 0, 1, 0, 5'b0);
    check("t3 di no disp", disp_stage, 3'd0);
    check("t3 di ime", ime, 1'b0);
    mcyc(1, 0, 0, 0, 5'b0);
    check("t3 di later no disp", disp_stage, 3'd0);
    check("t3 di later ime", ime, 1'b0);

    // Cancel: IE cleared during PUSH_HI
    mcyc(1, 0, 0, 1, 5'b0);
    check("t4 stage1", disp_stage, 3'd1);
    repeat (2) mcyc(0, 0, 0, 0, 5'b0);
    check("t4 stage3", disp_stage, 3'd3);
    write_ie(8'h00);
    mcyc(0, 0, 0, 0, 5'b0);
    check("t4 vector zero", vector, 8'h00);
    check("t4 if kept", if_rdata, 8'hE1);
    mcyc(0, 0, 0, 0, 5'b0);
    check("t4 jump vvalid", vector_valid, 1'b1);
    mcyc(0, 0, 0, 0, 5'b0);
    check("t4 idle", disp_stage, 3'd0);

    // Set wins over dispatch clear of the same bit
    write_if_src(5'h00, 5'b0);
    write_ie(8'h08);
    mcyc(1, 0, 0, 1, 5'b0);
    check("t5 ime on", ime, 1'b1);
    write_if_src(5'h08, 5'b0);
    mcyc(1, 0, 0, 0, 5'b0);
    repeat (2) mcyc(0, 0, 0, 0, 5'b0);
    check("t5 stage3", disp_stage, 3'd3);
    mcyc(0, 0, 0, 0, 5'b01000);
    check("t5 vector", vector, 8'h58);
    check("t5 if3 resets", if_rdata, 8'hE8);
    repeat (2) mcyc(0, 0, 0, 0, 5'b0);
    check("t5 idle", disp_stage, 3'd0);
    write_if_src(5'h00, 5'b00010);     // write 0 with src[1] in the same clk
    check("t5 write vs set", if_rdata, 8'hE2);

    // HALT wake and halt bug
    write_if_src(5'h00, 5'b0);
    write_ie(8'h04);
    halted = 1'b1;
    mcyc(1, 0, 0, 0, 5'b0);
    check("t6 wake low", wake, 1'b0);
    pulse_src(5'b00100);
    check("t6 wake high", wake, 1'b1);
    mcyc(1, 0, 0, 0, 5'b0);
    check("t6 no dispatch", disp_stage, 3'd0);
    check("t6 no hb held", halt_bug, 1'b0);
    halted = 1'b0;
    mcyc(0, 0, 0, 0, 5'b0);
    halted = 1'b1;
    mcyc(0, 0, 0, 0, 5'b0);
    check("t6 halt_bug pulse", halt_bug, exp_hb);
    mcyc(0, 0, 0, 0, 5'b0);
    check("t6 halt_bug end", halt_bug, 1'b0);

    // Reset mid-dispatch
    halted = 1'b0;
    mcyc(1, 0, 0, 1, 5'b0);
    mcyc(0, 0, 0, 0, 5'b0);
    check("t7 stage2", disp_stage, 3'd2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t7 stage", disp_stage, 3'd0);
    check("t7 dispatch", dispatch, 1'b0);
    check("t7 if", if_rdata, 8'hE0);
    check("t7 ie", ie_rdata, 8'h00);
    check("t7 ime", ime, 1'b0);
    check("t7 vector", vector, 8'h00);
    mcyc(1, 0, 0, 0, 5'b0);
    check("t7 stays idle", disp_stage, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
